// File: rtl/vga_pkg.sv
// vga_pkg: shared VGA text-path constants and the text sequencer state type
//   SPACE           blank character code sent to the font ROM
//   TXT_CELLS       character cells per text page (8 rows x 16 cols)
//   txt_seq_state_t text sequencer FSM states
package vga_pkg;
   localparam logic [6:0] SPACE = 7'h20;
   localparam int TXT_CELLS = 128;
   typedef enum logic [1:0] {IDLE, TYPING, WAIT_BTN} txt_seq_state_t;
endpackage

// File: rtl/game_txt_frame_div.sv
// game_txt_frame_div: divides frame ticks into character reveal steps
//   clk, rst   clock and synchronous active-high reset
//   clr        synchronous clear of the frame counter (also blocks char_step)
//   tick       one-cycle frame pulse
//   char_step  one-cycle pulse on every FRAMES_PER_CHAR-th counted tick
module game_txt_frame_div #(
   parameter int FRAMES_PER_CHAR = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic tick,
   output logic char_step
);
   localparam int CW = FRAMES_PER_CHAR > 1 ? $clog2(FRAMES_PER_CHAR) : 1;
   localparam logic [CW-1:0] LAST = CW'(FRAMES_PER_CHAR - 1);
   logic [CW-1:0] frame_cnt;
   assign char_step = tick && !clr && frame_cnt == LAST;
   always_ff @(posedge clk)
      if (rst || clr) frame_cnt <= '0;
      else if (tick) frame_cnt <= char_step ? '0 : frame_cnt + 1'b1;
endmodule

// File: rtl/game_txt_sequencer.sv
// game_txt_sequencer: typewriter-style text page sequencer between renderer and page ROM
//   clk, rst    clock and synchronous active-high reset
//   frame_tick  one-cycle pulse per frame
//   start       begin sequence at start_page (clamped to the last page)
//   btn_next    debounced button level; rising edge skips / advances pages
//   char_xy     {row, col} cell index from the char renderer
//   rom_code    selected page ROM output, one cycle behind char_xy
//   page_sel    page ROM mux select
//   char_code   masked character code, two cycles behind char_xy
//   busy        high while typing or waiting for the button
//   seq_done    one-cycle pulse after the last page is dismissed
module game_txt_sequencer import vga_pkg::*; #(
   parameter int NUM_PAGES       = 4,
   parameter int FRAMES_PER_CHAR = 2,
   parameter int PAGE_W          = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              frame_tick,
   input  logic              start,
   input  logic [PAGE_W-1:0] start_page,
   input  logic              btn_next,
   input  logic [7:0]        char_xy,
   input  logic [6:0]        rom_code,
   output logic [PAGE_W-1:0] page_sel,
   output logic [6:0]        char_code,
   output logic              busy,
   output logic              seq_done
);
   txt_seq_state_t state;
   logic [8:0] reveal_cnt;
   logic btn_q, btn_rise, reveal_q, char_step;
   assign btn_rise = btn_next & ~btn_q;
   assign busy = state == TYPING || state == WAIT_BTN;
   // a skip press in the same cycle as a frame tick must not also count a frame
   game_txt_frame_div #(.FRAMES_PER_CHAR(FRAMES_PER_CHAR)) u_div (
      .clk      (clk),
      .rst      (rst),
      .clr      (state != TYPING || btn_rise),
      .tick     (frame_tick),
      .char_step(char_step)
   );
   always_ff @(posedge clk)
      if (rst) begin
         state      <= IDLE;
         page_sel   <= '0;
         reveal_cnt <= '0;
         reveal_q   <= 1'b0;
         char_code  <= SPACE;
         seq_done   <= 1'b0;
         btn_q      <= 1'b0;
      end else begin
         btn_q     <= btn_next;
         // reveal is delayed one cycle so it lines up with the ROM's read latency
         reveal_q  <= {1'b0, char_xy} < reveal_cnt;
         char_code <= (state != IDLE && reveal_q) ? rom_code : SPACE;
         seq_done  <= 1'b0;
         case (state)
            IDLE:
               if (start) begin
                  state      <= TYPING;
                  page_sel   <= int'(start_page) >= NUM_PAGES ? PAGE_W'(NUM_PAGES - 1) : start_page;
                  reveal_cnt <= '0;
               end
            TYPING:
               if (btn_rise) begin
                  reveal_cnt <= 9'(TXT_CELLS);
                  state      <= WAIT_BTN;
               end else if (char_step) begin
                  reveal_cnt <= reveal_cnt + 9'd1;
                  if (reveal_cnt == 9'(TXT_CELLS - 1)) state <= WAIT_BTN;
               end
            WAIT_BTN:
               if (btn_rise) begin
                  if (int'(page_sel) < NUM_PAGES - 1) begin
                     page_sel   <= page_sel + 1'b1;
                     reveal_cnt <= '0;
                     state      <= TYPING;
                  end else begin
                     state    <= IDLE;
                     seq_done <= 1'b1;
                  end
               end
            default: state <= IDLE;
         endcase
      end
endmodule

// File: tb/tb_game_txt_sequencer.sv
// tb_game_txt_sequencer: randomized check of the text sequencer against a page/tick-count model
module tb_game_txt_sequencer;
   import vga_pkg::*;
   localparam int NP = 4, FPC = 2, PW = 3;
   logic clk = 1'b0, rst = 1'b1, frame_tick = 1'b0, start = 1'b0, btn_next = 1'b0;
   logic [PW-1:0] start_page = '0;
   logic [7:0] char_xy = '0;
   logic [6:0] rom_code;
   logic [PW-1:0] page_sel;
   logic [6:0] char_code;
   logic busy, seq_done;
   int n_checks = 0, n_errors = 0;
   int m_mode = 0, m_page = 0, m_ticks = 0;
   bit m_skip = 0, m_btn = 0, m_done = 0, m_rq = 0;
   logic [6:0] m_rom = SPACE, m_cc = SPACE;
   bit b = 0;
   always #5 clk = ~clk;
   game_txt_sequencer #(.NUM_PAGES(NP), .FRAMES_PER_CHAR(FPC), .PAGE_W(PW)) dut (
      .clk(clk), .rst(rst), .frame_tick(frame_tick), .start(start), .start_page(start_page),
      .btn_next(btn_next), .char_xy(char_xy), .rom_code(rom_code), .page_sel(page_sel),
      .char_code(char_code), .busy(busy), .seq_done(seq_done)
   );
   function automatic logic [6:0] rom_fn(logic [7:0] xy);
      return 7'h40 | {1'b0, xy[5:0]};
   endfunction
   always_ff @(posedge clk) rom_code <= rom_fn(char_xy);
   function automatic int revealed();
      if (m_skip) return 128;
      return m_ticks / FPC > 128 ? 128 : m_ticks / FPC;
   endfunction
   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask
   task automatic cyc(bit r, bit t, bit s, logic [PW-1:0] sp, bit bn, logic [7:0] xy);
      int rev;
      bit rise;
      rev = revealed();
      rise = bn && !m_btn;
      rst = r; frame_tick = t; start = s; start_page = sp; btn_next = bn; char_xy = xy;
      if (r) begin
         m_mode = 0; m_page = 0; m_ticks = 0; m_skip = 0; m_btn = 0; m_done = 0; m_rq = 0; m_cc = SPACE;
      end else begin
         m_cc = (m_mode != 0 && m_rq) ? m_rom : SPACE;
         m_rq = int'(xy) < rev;
         m_done = 0;
         m_btn = bn;
         if (m_mode == 0) begin
            if (s) begin
               m_mode = 1; m_page = int'(sp) > NP - 1 ? NP - 1 : int'(sp); m_ticks = 0; m_skip = 0;
            end
         end else if (m_mode == 1) begin
            if (rise) begin
               m_skip = 1; m_mode = 2;
            end else if (t) begin
               m_ticks++;
               if (m_ticks / FPC >= 128) m_mode = 2;
            end
         end else if (rise) begin
            if (m_page < NP - 1) begin
               m_page++; m_ticks = 0; m_skip = 0; m_mode = 1;
            end else begin
               m_mode = 0; m_done = 1;
            end
         end
      end
      m_rom = rom_fn(xy);
      @(posedge clk);
      @(negedge clk);
      chk("page_sel", 32'(page_sel), 32'(m_page));
      chk("char_code", 32'(char_code), 32'(m_cc));
      chk("busy", 32'(busy), 32'(m_mode != 0));
      chk("seq_done", 32'(seq_done), 32'(m_done));
   endtask
   initial begin
      repeat (3) cyc(1, 0, 0, 0, 0, 0);
      chk("rst_char", 32'(char_code), 32'(SPACE));
      chk("rst_busy", 32'(busy), 0);
      cyc(0, 0, 1, 1, 0, 0);
      repeat (6) begin
         cyc(0, 1, 0, 0, 0, 0);
         cyc(0, 0, 0, 0, 0, 0);
      end
      cyc(0, 0, 0, 0, 0, 8'h02);
      cyc(0, 0, 0, 0, 0, 8'h03);
      chk("xy02_shown", 32'(char_code), 32'h42);
      cyc(0, 0, 0, 0, 0, 8'h00);
      chk("xy03_space", 32'(char_code), 32'(SPACE));
      cyc(0, 1, 0, 0, 1, 0);
      chk("skip_busy", 32'(busy), 1);
      cyc(0, 0, 0, 0, 0, 8'h7F);
      cyc(0, 0, 0, 0, 0, 8'h00);
      chk("skip_7f", 32'(char_code), 32'h7F);
      cyc(0, 0, 0, 0, 1, 0);
      chk("next_page", 32'(page_sel), 2);
      cyc(0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0);
      chk("new_page_space", 32'(char_code), 32'(SPACE));
      repeat (3) begin
         cyc(0, 0, 0, 0, 1, 0);
         cyc(0, 0, 0, 0, 0, 0);
      end
      cyc(0, 0, 0, 0, 1, 0);
      chk("done_pulse", 32'(seq_done), 1);
      chk("done_idle", 32'(busy), 0);
      repeat (10) cyc(0, 0, 0, 0, 1, 0);
      chk("held_btn_idle", 32'(busy), 0);
      cyc(0, 0, 1, 2, 0, 0);
      repeat (3) cyc(0, 1, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0, 0);
      chk("rst_mid_page", 32'(page_sel), 0);
      chk("rst_no_done", 32'(seq_done), 0);
      cyc(0, 0, 1, 7, 0, 0);
      chk("clamp_page", 32'(page_sel), 3);
      repeat (700) begin
         if ($urandom_range(0, 299) == 0) b = ~b;
         cyc(0, 1, $urandom_range(0, 49) == 0, PW'($urandom_range(0, 7)), b, 8'($urandom_range(0, 255)));
      end
      repeat (2000) begin
         if ($urandom_range(0, 7) == 0) b = ~b;
         cyc($urandom_range(0, 299) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 19) == 0,
             PW'($urandom_range(0, 7)), b, 8'($urandom_range(0, 255)));
      end
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
